// File: rtl/sdram_arbiter.sv
// SDRAM port arbiter: port 0 (video) has strict priority, ports 1..N-1 are
// served round-robin. One transaction is in flight at a time. Read data and
// completion go only to the owning port, and only while BUSY.
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_PORTS-1:0]      port_request,
    input  logic [NUM_PORTS-1:0]      port_write,
    input  logic [NUM_PORTS*26-1:0]   port_address,
    input  logic [NUM_PORTS*32-1:0]   port_wdata,
    input  logic [NUM_PORTS*4-1:0]    port_wmask,
    output logic [NUM_PORTS-1:0]      port_ready,
    output logic [NUM_PORTS-1:0]      port_rvalid,
    output logic [NUM_PORTS-1:0]      port_complete,
    output logic [31:0]               rdata,
    output logic [25:0]               raddress,
    output logic                      sdram_request,
    output logic                      sdram_write,
    output logic [25:0]               sdram_address,
    output logic [31:0]               sdram_wdata,
    output logic [3:0]                sdram_wmask,
    input  logic                      sdram_ready,
    input  logic                      sdram_rvalid,
    input  logic [31:0]               sdram_rdata,
    input  logic [25:0]               sdram_raddress,
    input  logic                      sdram_complete,
    output logic                      timeout_error
);

    localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_q, rr_d;
    logic            write_q, write_d;
    logic [25:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [15:0]     wait_q, wait_d;
    logic            terr_q, terr_d;
    logic [OW-1:0]   rr_sel;

    // First requesting low-priority port, scanning from start and wrapping N-1 -> 1.
    function automatic logic [OW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [OW-1:0]        start);
        logic [OW-1:0] sel;
        logic          found;
        int            idx;
        sel   = OW'(1);
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS - 1; k++) begin
            idx = int'(start) + k;
            idx = (idx >= NUM_PORTS) ? idx - (NUM_PORTS - 1) : idx;
            if (!found && req[OW'(idx)]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    assign rr_sel        = rr_pick(port_request, rr_q);
    assign sdram_request = (state_q == ST_GRANT);
    assign sdram_write   = write_q;
    assign sdram_address = addr_q;
    assign sdram_wdata   = wdata_q;
    assign sdram_wmask   = wmask_q;
    assign rdata         = sdram_rdata;
    assign raddress      = sdram_raddress;
    assign timeout_error = terr_q;

    // State and command registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= OW'(0);
            rr_q    <= OW'(1);
            write_q <= 1'b0;
            addr_q  <= 26'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            wait_q  <= 16'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wait_q  <= wait_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state logic, command capture and per-port response routing.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        wait_d        = wait_q;
        terr_d        = terr_q;
        port_ready    = {NUM_PORTS{1'b0}};
        port_rvalid   = {NUM_PORTS{1'b0}};
        port_complete = {NUM_PORTS{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (|port_request) begin
                    owner_d = port_request[0] ? OW'(0) : rr_sel;
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (owner_d == OW'(i)) begin
                            write_d = port_write[i];
                            addr_d  = port_address[i*26 +: 26];
                            wdata_d = port_wdata[i*32 +: 32];
                            wmask_d = port_wmask[i*4 +: 4];
                        end else begin
                            write_d = write_d;
                        end
                    end
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (sdram_ready) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        port_ready[i] = (owner_q == OW'(i));
                    end
                    state_d = ST_BUSY;
                    wait_d  = 16'd0;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    port_rvalid[i]   = sdram_rvalid   && (owner_q == OW'(i));
                    port_complete[i] = sdram_complete && (owner_q == OW'(i));
                end
                if (sdram_complete) begin
                    state_d = ST_IDLE;
                    if (owner_q != OW'(0)) begin
                        rr_d = (owner_q == OW'(NUM_PORTS - 1)) ? OW'(1) : owner_q + OW'(1);
                    end else begin
                        rr_d = rr_q;
                    end
                end else if (wait_q == 16'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
